// File: rtl/j1_wb_pkg.sv
// Shared types and defaults for the J1 Wishbone master.
// The state encoding, timeout and error-data defaults live here so the top and the timeout counter agree on them.
package j1_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } wbm_state_t;

    localparam int          TIMEOUT_DEFAULT  = 255;
    localparam logic [15:0] ERR_DATA_DEFAULT = 16'hFFFF;

    // Counter width needed to reach TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/if_wb.sv
// Classic pipelined Wishbone bus, 16-bit address and data.
// The master drives the request side; the slave drives ack, stall and read data.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat_m;
    logic [15:0] dat_s;
    logic        ack;
    logic        stall;
    logic        rst;

    modport master (
        output cyc, stb, we, adr, dat_m,
        input  ack, stall, dat_s
    );

    modport slave (
        input  cyc, stb, we, adr, dat_m, rst,
        output ack, stall, dat_s
    );
endinterface

// File: rtl/wb_timeout.sv
// Saturating cycle counter that flags when a bus transfer has used its whole budget.
// The count is cleared when a request is latched and advances on every cycle the bus is busy.
module wb_timeout
    import j1_wb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int           W    = cnt_width(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign expired = en && (r_cnt == LAST);

endmodule

// File: rtl/j1_wb_master.sv
// Bridges the J1 single-cycle I/O strobes onto pipelined Wishbone, one transfer in flight.
// The CPU is held on io_busy until the slave acks or the timeout aborts the cycle.
module j1_wb_master
    import j1_wb_pkg::*;
#(
    parameter int          TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [15:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    output logic        io_busy,
    output logic        bus_err,
    input  logic        err_clr,
    if_wb.master        wb
);

    wbm_state_t  r_state;
    wbm_state_t  w_state_next;
    logic [15:0] r_adr;
    logic [15:0] r_dat;
    logic [15:0] r_din;
    logic        r_we;
    logic        r_err;

    logic        w_req;
    logic        w_accept;
    logic        w_done;
    logic        w_abort;
    logic        w_expired;
    logic        w_active;

    assign w_req    = io_rd | io_wr;
    assign w_active = (r_state != IDLE);
    assign w_accept = (r_state == IDLE) && w_req;

    wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_accept),
        .en      (w_active),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An ack in the last budgeted cycle still completes; only a missing ack aborts.
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (!wb.stall && wb.ack) begin
                    w_done = 1'b1;
                end else if (!wb.stall) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_done = wb.ack;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        if (w_done) begin
            w_state_next = IDLE;
        end else if (w_expired) begin
            w_abort      = 1'b1;
            w_state_next = IDLE;
        end
    end

    // A simultaneous read and write collapses to a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adr <= '0;
            r_dat <= '0;
            r_we  <= 1'b0;
        end else if (w_accept) begin
            r_adr <= io_addr;
            r_dat <= io_dout;
            r_we  <= io_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_din <= '0;
        end else if (w_done && !r_we) begin
            r_din <= wb.dat_s;
        end else if (w_abort && !r_we) begin
            r_din <= ERR_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_abort) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign wb.cyc   = w_active;
    assign wb.stb   = (r_state == REQ);
    assign wb.we    = r_we;
    assign wb.adr   = r_adr;
    assign wb.dat_m = r_dat;

    assign io_din  = r_din;
    assign io_busy = w_active | w_req;
    assign bus_err = r_err;

endmodule

// File: tb/tb_j1_wb_master.sv
// Scoreboard bench for j1_wb_master: directed transfers against a configurable Wishbone slave model.
// Expected bus beats and CPU-side completions are queued at issue time and popped by two monitors.
module tb_j1_wb_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_addr;
    logic [15:0] io_dout;
    logic [15:0] io_din;
    logic        io_busy;
    logic        bus_err;
    logic        err_clr;

    always #5 clk = ~clk;

    if_wb wb_bus ();

    j1_wb_master #(
        .TIMEOUT  (8),
        .ERR_DATA (16'hFFFF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .io_rd   (io_rd),
        .io_wr   (io_wr),
        .io_addr (io_addr),
        .io_dout (io_dout),
        .io_din  (io_din),
        .io_busy (io_busy),
        .bus_err (bus_err),
        .err_clr (err_clr),
        .wb      (wb_bus)
    );

    // Slave model: stalls cfg_stall cycles per beat, then acks registered or combinationally.
    int          cfg_stall   = 0;
    logic        cfg_ack_en  = 1'b1;
    logic        cfg_comb    = 1'b0;
    logic        force_ack   = 1'b0;
    logic [15:0] cfg_rdata   = 16'h0000;
    int          s_stall_cnt = 0;
    logic        s_ack_reg   = 1'b0;

    assign wb_bus.stall = wb_bus.cyc && wb_bus.stb && (s_stall_cnt < cfg_stall);
    assign wb_bus.ack   = (cfg_comb ? (cfg_ack_en && wb_bus.cyc && wb_bus.stb && !wb_bus.stall)
                                    : s_ack_reg) | force_ack;
    assign wb_bus.dat_s = cfg_rdata;
    assign wb_bus.rst   = ~rst_n;

    always @(posedge clk) begin
        if (wb_bus.cyc && wb_bus.stb && wb_bus.stall) begin
            s_stall_cnt <= s_stall_cnt + 1;
        end else if (wb_bus.cyc && wb_bus.stb) begin
            s_stall_cnt <= 0;
        end
        s_ack_reg <= cfg_ack_en && !cfg_comb && wb_bus.cyc && wb_bus.stb && !wb_bus.stall;
    end

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [15:0] dat;
        int          stbs;
    } bus_exp_t;

    typedef struct {
        logic [15:0] din;
        logic        err;
        int          busy;
    } rsp_exp_t;

    bus_exp_t exp_bus[$];
    rsp_exp_t exp_rsp[$];
    int       n_tests = 0;
    int       n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic void push(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                                 input int stbs, input logic [15:0] din, input logic err,
                                 input int busy);
        bus_exp_t b;
        rsp_exp_t r;
        b.we = we; b.adr = adr; b.dat = dat; b.stbs = stbs;
        r.din = din; r.err = err; r.busy = busy;
        exp_bus.push_back(b);
        exp_rsp.push_back(r);
    endfunction

    // Bus monitor: every stb cycle must match the head beat; the accepting cycle pops it.
    initial begin : bus_mon
        int       stb_cnt;
        bus_exp_t e;
        stb_cnt = 0;
        forever begin
            @(negedge clk);
            if (wb_bus.cyc && wb_bus.stb) begin
                stb_cnt++;
                if (exp_bus.size() == 0) begin
                    check("unexpected_stb", 32'(exp_bus.size()), 32'd1);
                end else begin
                    e = exp_bus[0];
                    check("stb_we", 32'(wb_bus.we), 32'(e.we));
                    check("stb_adr", 32'(wb_bus.adr), 32'(e.adr));
                    if (e.we) check("stb_dat", 32'(wb_bus.dat_m), 32'(e.dat));
                    if (!wb_bus.stall) begin
                        check("stb_cycles", 32'(stb_cnt), 32'(e.stbs));
                        void'(exp_bus.pop_front());
                    end
                end
                if (!wb_bus.stall) stb_cnt = 0;
            end
        end
    end

    // Completion monitor: fires in the cycle cyc drops and checks what the CPU sees.
    initial begin : rsp_mon
        int       busy_cnt;
        logic     prev_cyc;
        rsp_exp_t r;
        busy_cnt = 0;
        prev_cyc = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_cyc && !wb_bus.cyc) begin
                if (exp_rsp.size() == 0) begin
                    check("unexpected_done", 32'(exp_rsp.size()), 32'd1);
                end else begin
                    r = exp_rsp.pop_front();
                    check("io_din", 32'(io_din), 32'(r.din));
                    check("bus_err", 32'(bus_err), 32'(r.err));
                    check("busy_cycles", 32'(busy_cnt), 32'(r.busy));
                end
                busy_cnt = io_busy ? 1 : 0;
            end else if (io_busy) begin
                busy_cnt++;
            end
            if (!rst_n) busy_cnt = 0;
            prev_cyc = wb_bus.cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called 1 time unit after a posedge; returns 1 unit after the posedge where cyc dropped.
    task automatic xfer(input logic rd, input logic wr, input logic [15:0] adr, input logic [15:0] dat);
        int k;
        io_rd = rd; io_wr = wr; io_addr = adr; io_dout = dat;
        @(posedge clk);
        #1;
        io_rd = 1'b0; io_wr = 1'b0;
        k = 0;
        while (wb_bus.cyc && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("xfer_cyc_released", 32'(wb_bus.cyc), 32'd0);
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0; io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_dout = '0; err_clr = 1'b0;
        idle(2);
        check("rst_cyc", 32'(wb_bus.cyc), 32'd0);
        check("rst_stb", 32'(wb_bus.stb), 32'd0);
        check("rst_we", 32'(wb_bus.we), 32'd0);
        check("rst_adr", 32'(wb_bus.adr), 32'd0);
        check("rst_dat", 32'(wb_bus.dat_m), 32'd0);
        check("rst_io_din", 32'(io_din), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_busy_idle", 32'(io_busy), 32'd0);
        io_rd = 1'b1;
        #1;
        check("rst_busy_req", 32'(io_busy), 32'd1);
        io_rd = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);

        // Plain write, registered ack.
        push(1'b1, 16'h0010, 16'h1234, 1, 16'h0000, 1'b0, 3);
        xfer(1'b0, 1'b1, 16'h0010, 16'h1234);
        idle(1);

        // Plain read.
        cfg_rdata = 16'hBEEF;
        push(1'b0, 16'h0020, 16'h0000, 1, 16'hBEEF, 1'b0, 3);
        xfer(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(1);

        // Four stall cycles: five stb cycles, io_din untouched by the write.
        cfg_stall = 4;
        push(1'b1, 16'h0030, 16'h5A5A, 5, 16'hBEEF, 1'b0, 7);
        xfer(1'b0, 1'b1, 16'h0030, 16'h5A5A);
        cfg_stall = 0;
        idle(1);

        // Combinational ack completes straight from REQ.
        cfg_comb = 1'b1; cfg_rdata = 16'h1357;
        push(1'b0, 16'h0040, 16'h0000, 1, 16'h1357, 1'b0, 2);
        xfer(1'b1, 1'b0, 16'h0040, 16'h0000);
        cfg_comb = 1'b0;
        idle(1);

        // No ack: abort after 8 bus cycles with error data and sticky flag.
        cfg_ack_en = 1'b0;
        push(1'b0, 16'h0050, 16'h0000, 1, 16'hFFFF, 1'b1, 9);
        xfer(1'b1, 1'b0, 16'h0050, 16'h0000);
        cfg_ack_en = 1'b1;
        idle(2);
        check("err_sticky", 32'(bus_err), 32'd1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("err_cleared", 32'(bus_err), 32'd0);

        cfg_rdata = 16'h2468;
        push(1'b0, 16'h0060, 16'h0000, 1, 16'h2468, 1'b0, 3);
        xfer(1'b1, 1'b0, 16'h0060, 16'h0000);
        idle(1);

        // Read and write together: a single write beat.
        push(1'b1, 16'h0070, 16'hC0DE, 1, 16'h2468, 1'b0, 3);
        xfer(1'b1, 1'b1, 16'h0070, 16'hC0DE);
        idle(1);

        // Back-to-back write then read with no idle cycle between.
        cfg_rdata = 16'hABCD;
        push(1'b1, 16'h0080, 16'h1111, 1, 16'h2468, 1'b0, 3);
        push(1'b0, 16'h0090, 16'h0000, 1, 16'hABCD, 1'b0, 3);
        xfer(1'b0, 1'b1, 16'h0080, 16'h1111);
        xfer(1'b1, 1'b0, 16'h0090, 16'h0000);
        idle(1);

        // Reset asserted while in WAIT, then a late ack in IDLE.
        cfg_ack_en = 1'b0;
        push(1'b0, 16'h00A0, 16'h0000, 1, 16'h0000, 1'b0, 3);
        io_rd = 1'b1; io_addr = 16'h00A0;
        idle(1);
        io_rd = 1'b0;
        idle(1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_wait_cyc", 32'(wb_bus.cyc), 32'd0);
        check("rst_wait_stb", 32'(wb_bus.stb), 32'd0);
        check("rst_wait_din", 32'(io_din), 32'd0);
        idle(2);
        rst_n = 1'b1;
        force_ack = 1'b1;
        idle(1);
        force_ack = 1'b0;
        idle(1);
        check("late_ack_cyc", 32'(wb_bus.cyc), 32'd0);
        check("late_ack_din", 32'(io_din), 32'd0);
        check("late_ack_busy", 32'(io_busy), 32'd0);
        cfg_ack_en = 1'b1;

        cfg_rdata = 16'h0F0F;
        push(1'b0, 16'h00B0, 16'h0000, 1, 16'h0F0F, 1'b0, 3);
        xfer(1'b1, 1'b0, 16'h00B0, 16'h0000);
        idle(3);

        check("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
